// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver feeding the ALU command path through a one-byte holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the last data bit and the stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 521
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    logic          rx_meta;
    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tick;
    logic          byte_done;
    logic          stop_bad;
`ifdef UART_RX_PARITY_EN
    logic          par_bad;
    logic          par_flag;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd_i;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (cnt == '0);

    // byte_done/stop_bad/par_flag are one-cycle strobes raised at the stop-bit sample;
    // the output stage turns them into data, valid and error pulses on the following edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_done <= 1'b0;
            stop_bad  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
            par_flag  <= 1'b0;
`endif
        end else begin
            byte_done <= 1'b0;
            stop_bad  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_flag  <= 1'b0;
`endif
            if (state != S_IDLE && state != S_BREAK) begin
                cnt <= tick ? FULL_LOAD : cnt - CW'(1);
            end
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= HALF_LOAD;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            par_bad <= 1'b0;
`endif
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        par_bad <= ^{shift, rx_s};
                        state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        stop_bad <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                        byte_done <= rx_s & ~par_bad;
                        par_flag  <= par_bad;
`else
                        byte_done <= rx_s;
`endif
                        state <= rx_s ? S_IDLE : S_BREAK;
                    end
                end
                S_BREAK: begin
                    // Held-low line after a bad stop bit: do not re-arm until it idles high.
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake: a byte transfers on any edge where valid_o && ready_i; data_o is frozen
    // while valid_o is high and not yet accepted, and a new byte arriving then is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o      <= 8'h00;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= stop_bad;
            overrun_o   <= byte_done & valid_o & ~ready_i;
            if (byte_done && (!valid_o || ready_i)) begin
                data_o  <= shift;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            parity_err_o <= 1'b0;
        end else begin
            parity_err_o <= par_flag;
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus for uart_rx checked against a byte-level expected queue.
// Honours UART_RX_PARITY_EN so the same bench drives both frame formats.
module tb_uart_rx;
    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int LATENCY    = 3 + C / 2 + 9 * C + 1 + C;
`else
    localparam int FRAME_BITS = 10;
    localparam int LATENCY    = 3 + C / 2 + 9 * C + 1;
`endif
    localparam int FRAME = FRAME_BITS * C;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       rxd_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       parity_err_o;

    logic [7:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int n_frame = 0;
    int n_overrun = 0;
    int n_parity = 0;
    int n_accept = 0;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rxd_i       (rxd_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .parity_err_o(parity_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rxd_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame LSB first, each bit held C cycles, starting at the current negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        logic [10:0] bits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^b) ^ par_flip;
        bits[10] = stop_bit;
`else
        bits[9]  = stop_bit;
        bits[10] = 1'b1 | par_flip;
`endif
        for (int i = 0; i < FRAME_BITS; i++) begin
            rxd_i = bits[i];
            repeat (C) @(negedge clk);
        end
    endtask

    // Monitor: samples just after each negedge, once inputs for the next edge are settled.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (frame_err_o)  n_frame++;
            if (overrun_o)    n_overrun++;
            if (parity_err_o) n_parity++;
            if (valid_o && ready_i) begin
                n_accept++;
                check("rx_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("rx_byte", 32'(data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int f0, o0, p0, a0, lat;
        logic [7:0] b;
        logic rnd_done;

        rst_i   = 1'b1;
        rxd_i   = 1'b1;
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",   32'(data_o), 32'h0);
        check("rst_valid",  32'(valid_o), 32'h0);
        check("rst_frame",  32'(frame_err_o), 32'h0);
        check("rst_overrun", 32'(overrun_o), 32'h0);
        check("rst_parity", 32'(parity_err_o), 32'h0);
        rst_i = 1'b0;
        idle(C);

        // Single byte with latency and one-cycle valid under ready high.
        f0 = n_frame; o0 = n_overrun; p0 = n_parity;
        exp_q.push_back(8'hA5);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                while (!valid_o && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
                check("a5_latency", 32'(lat), 32'(LATENCY));
                check("a5_data", 32'(data_o), 32'hA5);
                @(negedge clk);
                check("a5_valid_width", 32'(valid_o), 32'h0);
            end
        join
        idle(C);
        check("a5_no_frame_err", 32'(n_frame - f0), 32'd0);
        check("a5_no_overrun", 32'(n_overrun - o0), 32'd0);
        check("a5_no_parity_err", 32'(n_parity - p0), 32'd0);

        // Short low glitch on an idle line must be ignored.
        f0 = n_frame; a0 = n_accept;
        rxd_i = 1'b0;
        repeat (5) @(negedge clk);
        idle(2 * C);
        check("glitch_no_accept", 32'(n_accept - a0), 32'd0);
        check("glitch_no_frame_err", 32'(n_frame - f0), 32'd0);
        check("glitch_valid", 32'(valid_o), 32'h0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(C);
        check("glitch_next_accept", 32'(n_accept - a0), 32'd1);

        // Bad stop bit followed by a held-low line.
        f0 = n_frame; a0 = n_accept;
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("frame_held_low_frame_err", 32'(n_frame - f0), 32'd1);
        check("frame_held_low_accept", 32'(n_accept - a0), 32'd0);
        idle(2 * C);
        check("frame_after_high_frame_err", 32'(n_frame - f0), 32'd1);
        check("frame_valid", 32'(valid_o), 32'h0);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(C);
        check("frame_next_accept", 32'(n_accept - a0), 32'd1);

        // Overrun: consumer stalled across two back-to-back bytes.
        o0 = n_overrun;
        ready_i = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(C);
        check("ovr_valid", 32'(valid_o), 32'h1);
        check("ovr_data_held", 32'(data_o), 32'h11);
        check("ovr_pulses", 32'(n_overrun - o0), 32'd1);
        @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check("ovr_valid_cleared", 32'(valid_o), 32'h0);

        // Accept of the held byte in the very cycle the next byte completes.
        o0 = n_overrun;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        fork
            begin
                send_frame(8'h11, 1'b1, 1'b0);
                send_frame(8'h22, 1'b1, 1'b0);
            end
            begin
                repeat (FRAME + LATENCY - 1) @(negedge clk);
                ready_i = 1'b1;
                @(negedge clk);
                ready_i = 1'b0;
                check("simul_valid", 32'(valid_o), 32'h1);
                check("simul_data", 32'(data_o), 32'h22);
            end
        join
        idle(C);
        check("simul_no_overrun", 32'(n_overrun - o0), 32'd0);
        ready_i = 1'b1;
        idle(4);
        check("simul_drained", 32'(exp_q.size()), 32'd0);

        // Random bytes with random gaps and a random-ready consumer.
        f0 = n_frame; o0 = n_overrun;
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    b = 8'($urandom_range(0, 255));
                    exp_q.push_back(b);
                    send_frame(b, 1'b1, 1'b0);
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                end
                idle(C);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_i = 1'b1;
        idle(20);
        check("rnd_drained", 32'(exp_q.size()), 32'd0);
        check("rnd_no_overrun", 32'(n_overrun - o0), 32'd0);
        check("rnd_no_frame_err", 32'(n_frame - f0), 32'd0);

        // Reset in the middle of data bit 4 of 0xFF, then a clean 0x81.
        a0 = n_accept; f0 = n_frame;
        rxd_i = 1'b0;
        repeat (C) @(negedge clk);
        rxd_i = 1'b1;
        repeat (4 * C + C / 2) @(negedge clk);
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_data", 32'(data_o), 32'h0);
        check("midrst_valid", 32'(valid_o), 32'h0);
        check("midrst_frame", 32'(frame_err_o), 32'h0);
        check("midrst_overrun", 32'(overrun_o), 32'h0);
        check("midrst_parity", 32'(parity_err_o), 32'h0);
        rst_i = 1'b0;
        idle(2 * C);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(C);
        check("midrst_accepts", 32'(n_accept - a0), 32'd1);
        check("midrst_no_frame_err", 32'(n_frame - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
        p0 = n_parity; a0 = n_accept; f0 = n_frame;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(C);
        check("par_pulse", 32'(n_parity - p0), 32'd1);
        check("par_no_accept", 32'(n_accept - a0), 32'd0);
        check("par_valid", 32'(valid_o), 32'h0);
        send_frame(8'h07, 1'b0, 1'b1);
        idle(2 * C);
        check("par_both_parity", 32'(n_parity - p0), 32'd2);
        check("par_both_frame", 32'(n_frame - f0), 32'd1);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(C);
        check("par_good_accept", 32'(n_accept - a0), 32'd1);
`endif

        check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling 8N1 UART receiver that turns the serial `rxd_i` line into bytes for the ALU command path. It runs on the 60 MHz PLL clock and sits directly upstream of the ALU command decoder. It presents each received byte on a valid/ready interface with a one-byte holding register, and reports framing and overrun errors as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 521: clock cycles per bit (60 MHz / 115200 baud); legal range ≥ 4; counter width `$clog2(CLKS_PER_BIT)`.
- `clk_i` in 1: the single system clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `rxd_i` in 1: raw serial input, asynchronous to `clk_i`, idle high.
- `data_o` out 8: received byte, LSB first on the wire.
- `valid_o` out 1: `data_o` holds an unconsumed byte.
- `ready_i` in 1: consumer accepts the byte in any cycle where `valid_o && ready_i`.
- `frame_err_o` out 1: one-cycle pulse when the stop bit samples 0.
- `overrun_o` out 1: one-cycle pulse when a completed byte is dropped.
- `parity_err_o` out 1: one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.

## Operation
- **Input synchronizer:** two-flop synchronizer on `rxd_i`, both flops reset to 1. All FSM decisions use the synchronized bit `rx_s`.
- **Bit counter:** loads a value, decrements each cycle, and fires a *sample tick* in the cycle it reads 0, then reloads `CLKS_PER_BIT-1`.
- **IDLE:** when `rx_s==0`, load `CLKS_PER_BIT/2-1` (integer division) and go to START.
- **START:** at the tick:
  - `rx_s==0`: go to DATA with bit index 0.
  - `rx_s==1`: glitch; return to IDLE with no output and no error.
- **DATA:** at each tick, shift `rx_s` into bit[index]. After index 7, go to PARITY if enabled, else STOP.
- **STOP:** at the tick:
  - `rx_s==1` and no parity error latched: byte complete, return to IDLE.
  - `rx_s==0`: pulse `frame_err_o`, discard the byte, go to BREAK.
- **BREAK:** wait for `rx_s==1`, then go to IDLE. This stops a held-low line from being re-read as start bits.
- **Output holding register** (evaluated in the byte-complete cycle):
  - `valid_o==0`: load `data_o`; `valid_o` rises next cycle.
  - `valid_o==1 && ready_i==1`: the old byte is consumed, the new byte loads, `valid_o` stays 1.
  - `valid_o==1 && ready_i==0`: pulse `overrun_o`; the old byte is kept and the new byte is dropped.
- **Consume without new byte:** `valid_o && ready_i` with no completing byte clears `valid_o` next cycle.
- **`data_o` stability:** `data_o` never changes while `valid_o` is high and unaccepted.

## Timing
- **Reset values:**
  - `data_o=8'h00`, `valid_o=0`.
  - `frame_err_o=0`, `overrun_o=0`, `parity_err_o=0`.
  - State IDLE, counter and bit index 0, synchronizer flops 1.
- **Reset mid-frame:** asserting `rst_i` mid-frame aborts immediately. After release the receiver waits in IDLE for the next low `rx_s`.
- **Sample points:** the start bit is sampled `CLKS_PER_BIT/2` cycles after entering START. Each later bit is sampled `CLKS_PER_BIT` cycles after the previous one.
- **Latency** (no parity), from the `rxd_i` falling edge to `valid_o` high: 2 (synchronizer) + 1 (IDLE) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 cycles. Parity adds `CLKS_PER_BIT`.
- **Back-to-back frames:** the FSM returns to IDLE at the middle of the stop bit, so a start bit immediately after the stop bit is caught.
- **Error pulses:** high exactly one cycle, registered, aligned with the cycle `valid_o` would have risen.
- **Throughput:** one byte per frame. `ready_i` may be tied high.

## Configuration
- **Macro:** `UART_RX_PARITY_EN`.
- **Defined:**
  - A PARITY state follows DATA. It samples one bit at the tick and checks even parity (XOR of the 8 data bits and the parity bit must be 0).
  - On mismatch, STOP still runs. In the cycle where the byte would complete, `parity_err_o` pulses and the byte is discarded (`valid_o` unaffected).
  - If the stop bit is also 0, both error pulses fire in the same cycle.
- **Undefined:** the frame is 8N1, there is no PARITY state, and `parity_err_o` is constant 0.

## Test plan
- **Single byte:** `CLKS_PER_BIT=16`, `ready_i=1`, send 0xA5 in 8N1 → `valid_o` high for exactly 1 cycle with `data_o=8'hA5`; no error pulses; latency 2+1+8+144+1=156 cycles from the falling edge.
- **Glitch rejection:** 5-cycle low glitch on idle line → no `valid_o`, no `frame_err_o`, FSM back in IDLE; next frame 0x3C received correctly.
- **Framing error:** send 0x55 with stop bit 0, then hold the line low for 40 cycles, then high → one `frame_err_o` pulse, no `valid_o`, no further activity until the line returns high; next frame 0x0F received.
- **Overrun:** `ready_i=0`, send 0x11 then 0x22 back-to-back → `valid_o=1` with `data_o=8'h11` held, one `overrun_o` pulse at the second byte; raising `ready_i` clears `valid_o` next cycle.
- **Simultaneous accept and completion:** assert `ready_i` exactly in the completion cycle of the second byte → `valid_o` stays high, `data_o` changes 0x11→0x22, no `overrun_o`.
- **Reset and parity:** assert `rst_i` during data bit 4 of 0xFF, release, send 0x81 → all outputs 0 during reset; only 0x81 delivered. With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `parity_err_o` pulses, no `valid_o`.
